// File: rtl/paddle_filter.sv
// rtl/paddle_filter.sv - ADC sample moving average, clamp and optional deadband (macro PADDLE_FILTER_HYST_EN)
module paddle_filter #(
    parameter int WIDTH    = 7,
    parameter int AVG_LOG2 = 2,
    parameter int PAD_MIN  = 0,
    parameter int PAD_MAX  = 112,
    parameter int HYST     = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] ADCin,
    input  logic             ADCsampled,
    output logic [WIDTH-1:0] Pos,
    output logic             PosValid,
    output logic             Settled
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [WIDTH-1:0] PMIN = WIDTH'(PAD_MIN);
    localparam logic [WIDTH-1:0] PMAX = WIDTH'(PAD_MAX);

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] win_q [N];
    logic [SW-1:0]    sum_q;
    logic [SW-1:0]    sum_d;
    logic             sampled_q;
    logic             armed_q;
    logic             upd_q;
    logic             first_q;
    logic [WIDTH-1:0] pos_q;
    logic             pos_valid_q;
    logic             settled_q;

    logic             accept;
    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] lo_clamped;
    logic [WIDTH-1:0] clamped;
    logic             write_ok;

    // A strobe that is already high when reset releases must first be seen low
    // (armed_q) before its rising edge counts as a sample.
    assign accept = ADCsampled && !sampled_q && armed_q;

    // Running-sum update, truncating average and playfield clamp
    always_comb begin
        sum_d      = sum_q + {{AVG_LOG2{1'b0}}, ADCin} - {{AVG_LOG2{1'b0}}, win_q[N-1]};
        avg        = sum_q[SW-1:AVG_LOG2];
        lo_clamped = (avg > PMIN) ? avg : PMIN;
        clamped    = (lo_clamped < PMAX) ? lo_clamped : PMAX;
    end

`ifdef PADDLE_FILTER_HYST_EN
    logic [WIDTH:0] diff;
    logic [WIDTH:0] abs_diff;

    // Deadband: suppress writes whose distance from the shown position is within HYST
    always_comb begin
        diff     = {1'b0, clamped} - {1'b0, pos_q};
        abs_diff = diff[WIDTH] ? (~diff + 1'b1) : diff;
        write_ok = abs_diff > (WIDTH + 1)'(HYST);
    end
`else
    logic unused_hyst;
    assign unused_hyst = (HYST != 0);
    assign write_ok    = 1'b1;
`endif

    // Edge detect, window/sum, fill/run FSM and registered position output
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_FILL;
            count_q     <= '0;
            sum_q       <= '0;
            sampled_q   <= 1'b0;
            armed_q     <= 1'b0;
            upd_q       <= 1'b0;
            first_q     <= 1'b0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            settled_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            sampled_q   <= ADCsampled;
            pos_valid_q <= 1'b0;
            upd_q       <= 1'b0;
            if (!ADCsampled) begin
                armed_q <= 1'b1;
            end

            if (accept) begin
                sum_q    <= sum_d;
                win_q[0] <= ADCin;
                for (int i = N - 1; i > 0; i--) begin
                    win_q[i] <= win_q[i-1];
                end
            end

            case (state_q)
                S_FILL: begin
                    if (accept) begin
                        count_q <= count_q + CW'(1);
                        if (count_q == CW'(N - 1)) begin
                            state_q   <= S_RUN;
                            settled_q <= 1'b1;
                            upd_q     <= 1'b1;
                            first_q   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    upd_q <= accept;
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase

            // Sum was updated at the end of the accept cycle, so the average
            // used here already includes the new sample.
            if (upd_q && (first_q || write_ok)) begin
                pos_q       <= clamped;
                pos_valid_q <= 1'b1;
                first_q     <= 1'b0;
            end
        end
    end

    assign Pos      = pos_q;
    assign PosValid = pos_valid_q;
    assign Settled  = settled_q;

endmodule

// File: tb/tb_paddle_filter.sv
// tb/tb_paddle_filter.sv - randomized self-checking bench for paddle_filter against a queue-based model
module tb_paddle_filter;

    localparam int WIDTH   = 7;
    localparam int N       = 4;
    localparam int PAD_MIN = 0;
    localparam int PAD_MAX = 112;
    localparam int HYST    = 2;

    logic             CLK = 1'b0;
    logic             Reset = 1'b1;
    logic [WIDTH-1:0] ADCin = '0;
    logic             ADCsampled = 1'b0;
    logic [WIDTH-1:0] Pos;
    logic             PosValid;
    logic             Settled;

    int n_tests = 0;
    int n_fail  = 0;

    int win[$];
    int exp_pos   = 0;
    bit exp_first = 1'b1;
`ifdef PADDLE_FILTER_HYST_EN
    bit hyst_en = 1'b1;
`else
    bit hyst_en = 1'b0;
`endif

    paddle_filter dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .ADCin      (ADCin),
        .ADCsampled (ADCsampled),
        .Pos        (Pos),
        .PosValid   (PosValid),
        .Settled    (Settled)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_clamp(input int a);
        if (a < PAD_MIN) return PAD_MIN;
        if (a > PAD_MAX) return PAD_MAX;
        return a;
    endfunction

    task automatic model_reset();
        win.delete();
        exp_pos   = 0;
        exp_first = 1'b1;
    endtask

    // One accepted sample: returns whether Pos is expected to be written
    task automatic model_accept(input int v, output bit wr);
        int s, c, d;
        win.push_back(v);
        if (win.size() > N) void'(win.pop_front());
        wr = 1'b0;
        if (win.size() == N) begin
            s = 0;
            foreach (win[i]) s += win[i];
            c = model_clamp(s / N);
            d = c - exp_pos;
            if (d < 0) d = -d;
            if (!hyst_en || exp_first || d > HYST) begin
                wr        = 1'b1;
                exp_pos   = c;
                exp_first = 1'b0;
            end
        end
    endtask

    function automatic bit model_settled();
        return win.size() == N;
    endfunction

    // Single strobe then three observed cycles; idx is the observed cycle of the first pulse
    task automatic pulse(input int v, output int npulse, output int idx, output logic settled_seen);
        @(posedge CLK); #1;
        ADCin = WIDTH'(v);
        ADCsampled = 1'b1;
        @(posedge CLK); #1;
        ADCsampled = 1'b0;
        npulse = 0;
        idx = -1;
        settled_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 0) settled_seen = Settled;
            if (PosValid) begin
                npulse++;
                if (idx < 0) idx = i;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        Reset = 1'b1;
        ADCsampled = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        n_tests++;
        if (Pos !== 7'd0 || PosValid !== 1'b0 || Settled !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: Pos=%0d PosValid=%b Settled=%b, want 0 0 0", Pos, PosValid, Settled);
        end
    endtask

    // Fixed-value sequence; const_pos holds spec-given positions (-1 = no fixed value)
    task automatic test_seq(input string tag, input int vals[$], input int const_pos[$]);
        int np, idx;
        bit wr;
        logic st;
        for (int k = 0; k < vals.size(); k++) begin
            pulse(vals[k], np, idx, st);
            model_accept(vals[k], wr);
            n_tests++;
            if (np !== int'(wr) || (wr && idx !== 1)) begin
                n_fail++;
                $display("FAIL %s_pulse[%0d]: pulses=%0d at %0d, want %0d at 1", tag, k, np, idx, wr);
            end
            n_tests++;
            if (st !== model_settled()) begin
                n_fail++;
                $display("FAIL %s_settled[%0d]: got %b want %b", tag, k, st, model_settled());
            end
            n_tests++;
            if (int'(Pos) !== exp_pos) begin
                n_fail++;
                $display("FAIL %s_pos[%0d]: got %0d want %0d", tag, k, Pos, exp_pos);
            end
            if (const_pos[k] >= 0) begin
                n_tests++;
                if (int'(Pos) !== const_pos[k]) begin
                    n_fail++;
                    $display("FAIL %s_const[%0d]: got %0d want %0d", tag, k, Pos, const_pos[k]);
                end
            end
        end
    endtask

    task automatic test_fill();
        test_seq("fill", '{40, 40, 40, 40}, '{0, 0, 0, 40});
    endtask

    task automatic test_deadband();
        if (hyst_en) test_seq("deadband", '{41, 41, 41, 41}, '{40, 40, 40, 40});
        else         test_seq("deadband", '{41, 41, 41, 41}, '{40, 40, 40, 41});
    endtask

    task automatic test_step();
        test_seq("step", '{100, 100, 100, 100}, '{55, 70, 85, 100});
    endtask

    task automatic test_clamp();
        test_seq("clamp", '{127, 127, 127, 127}, '{106, 112, 112, 112});
    endtask

    task automatic test_held_strobe();
        int np;
        bit wr;
        @(posedge CLK); #1;
        ADCin = 7'd60;
        ADCsampled = 1'b1;
        np = 0;
        for (int c = 0; c < 13; c++) begin
            if (c == 10) begin
                @(posedge CLK); #1 ADCsampled = 1'b0;
            end
            @(negedge CLK);
            if (PosValid) np++;
        end
        model_accept(60, wr);
        n_tests++;
        if (np !== int'(wr) || np > 1) begin
            n_fail++;
            $display("FAIL held_strobe_pulses: got %0d want %0d", np, wr);
        end
        n_tests++;
        if (int'(Pos) !== exp_pos) begin
            n_fail++;
            $display("FAIL held_strobe_pos: got %0d want %0d", Pos, exp_pos);
        end
    endtask

    // Accepts at random values with spacing 2..4 cycles, every PosValid collected
    task automatic test_back_to_back(input int count);
        int vals[$];
        int gaps[$];
        int got[$];
        int want[$];
        int cyc, total;
        bit wr;
        for (int k = 0; k < count; k++) begin
            vals.push_back($urandom_range(0, 127));
            gaps.push_back($urandom_range(2, 4));
        end
        total = 0;
        foreach (gaps[k]) total += gaps[k];
        cyc = 0;
        for (int k = 0; k < count; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                @(posedge CLK); #1;
                ADCin = WIDTH'(vals[k]);
                ADCsampled = (g == 0);
                @(negedge CLK);
                if (PosValid) got.push_back(int'(Pos));
                cyc++;
            end
            model_accept(vals[k], wr);
            if (wr) want.push_back(exp_pos);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1 ADCsampled = 1'b0;
            @(negedge CLK);
            if (PosValid) got.push_back(int'(Pos));
        end
        n_tests++;
        if (got.size() !== want.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d updates want %0d over %0d cycles", got.size(), want.size(), cyc);
        end else begin
            for (int k = 0; k < want.size(); k++) begin
                n_tests++;
                if (got[k] !== want[k]) begin
                    n_fail++;
                    $display("FAIL b2b_pos[%0d]: got %0d want %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int np, idx;
        logic st;
        @(posedge CLK); #1;
        ADCin = 7'd20;
        ADCsampled = 1'b1;
        @(posedge CLK); #2;
        ADCsampled = 1'b0;
        Reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (Pos !== 7'd0 || PosValid !== 1'b0 || Settled !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: Pos=%0d PosValid=%b Settled=%b, want 0 0 0", Pos, PosValid, Settled);
        end
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        np = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (PosValid) np++;
        end
        n_tests++;
        if (np !== 0) begin
            n_fail++;
            $display("FAIL async_reset_inflight: got %0d pulses want 0", np);
        end
        for (int k = 0; k < 3; k++) begin
            pulse(30, np, idx, st);
            n_tests++;
            if (np !== 0 || st !== 1'b0) begin
                n_fail++;
                $display("FAIL async_refill[%0d]: pulses=%0d Settled=%b, want 0 0", k, np, st);
            end
        end
    endtask

    task automatic test_strobe_at_release();
        int np, idx;
        logic st;
        bit wr;
        @(posedge CLK); #1;
        Reset = 1'b1;
        ADCsampled = 1'b1;
        ADCin = 7'd50;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1 ADCsampled = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pulse(50, np, idx, st);
            model_accept(50, wr);
            n_tests++;
            if (np !== int'(wr) || st !== model_settled()) begin
                n_fail++;
                $display("FAIL release_strobe[%0d]: pulses=%0d Settled=%b, want %0d %b", k, np, st, wr, model_settled());
            end
        end
        n_tests++;
        if (Pos !== 7'd50) begin
            n_fail++;
            $display("FAIL release_strobe_pos: got %0d want 50", Pos);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_deadband();
        test_step();
        test_clamp();
        test_held_strobe();
        test_back_to_back(40);
        test_async_reset();
        test_strobe_at_release();
        test_back_to_back(40);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
